// File: rtl/sopc_bus_pkg.sv
// Shared definitions for the data-side bus fabric: FSM encoding,
// default watchdog limit, error read-data value and byte-enable width helper.
package sopc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bus_state_t;

  // BUSY cycles tolerated without an acknowledge
  localparam int DEF_TIMEOUT = 15;

  // Every bit of the read data returned on an errored access
  localparam logic ERR_DATA_BIT = 1'b0;

  // Number of byte lanes for a data bus of width data_w
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sopc_data_bus_if.sv
// Core-side data-memory port of the bus fabric. Member names are seen
// from the fabric: _i are driven by the core, _o by the fabric.
interface sopc_data_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = sopc_bus_pkg::be_width(DATA_W);

  logic              m_ce_i;
  logic              m_we_i;
  logic [ADDR_W-1:0] m_addr_i;
  logic [BE_W-1:0]   m_sel_i;
  logic [DATA_W-1:0] m_data_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_stall_o;
  logic              m_err_o;

  // Core side
  modport master (
    output m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
    input  m_data_o, m_stall_o, m_err_o
  );

  // Fabric side
  modport slave (
    input  m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
    output m_data_o, m_stall_o, m_err_o
  );
endinterface

// File: rtl/sopc_bus_watchdog.sv
// Cycle counter that flags when a slave has been waited on for TIMEOUT
// cycles. reached_o is high during the TIMEOUT-th enabled cycle.
module sopc_bus_watchdog #(
  parameter int TIMEOUT = sopc_bus_pkg::DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic reached_o
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign reached_o = (count_q == CW'(TIMEOUT - 1));

  // Next count: clear wins, otherwise count while enabled and below the limit
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !reached_o) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/sopc_data_bus.sv
// Data-side bus fabric: decodes the top address bits to one of NUM_SLAVES
// slaves, holds the latched request until the slave acks or the watchdog
// expires, stalls the core meanwhile and returns registered read data.
module sopc_data_bus
  import sopc_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  sopc_data_bus_if.slave               m_bus,
  output logic                         err_sticky_o,
  output logic [NUM_SLAVES-1:0]        s_ce_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [be_width(DATA_W)-1:0]  s_sel_o,
  output logic [DATA_W-1:0]            s_data_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i
);
  localparam int BE_W = be_width(DATA_W);
  localparam logic [SEL_BITS:0] NS_W = (SEL_BITS + 1)'(NUM_SLAVES);

  bus_state_t                state_q;
  logic                      we_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [BE_W-1:0]           sel_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [NUM_SLAVES-1:0]     ce_q;
  logic [DATA_W-1:0]         rdata_q;
  logic                      err_q;
  logic                      sticky_q;

  logic [SEL_BITS-1:0]       idx_s;
  logic                      mapped_s;
  logic [NUM_SLAVES-1:0]     onehot_s;
  logic                      ack_s;
  logic [DATA_W-1:0]         rdata_sel_s;
  logic                      reached_s;
  logic                      stall_s;

  assign idx_s    = m_bus.m_addr_i[ADDR_W-1 -: SEL_BITS];
  assign mapped_s = ({1'b0, idx_s} < NS_W);

  // Slave decode of the incoming address
  always_comb begin
    onehot_s = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      onehot_s[k] = (idx_s == SEL_BITS'(k));
    end
  end

  // Ack and read data of the currently selected slave only
  always_comb begin
    rdata_sel_s = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      rdata_sel_s = rdata_sel_s | (s_data_i[k*DATA_W +: DATA_W] & {DATA_W{ce_q[k]}});
    end
  end
  assign ack_s = |(s_ack_i & ce_q);

  sopc_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == ST_IDLE),
    .en_i      (state_q == ST_BUSY),
    .reached_o (reached_s)
  );

  // Stall: follows the request in IDLE so the core holds until completion
  always_comb begin
    case (state_q)
      ST_IDLE: stall_s = m_bus.m_ce_i;
      ST_BUSY: stall_s = 1'b1;
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // Request FSM with latched slave bus, read data and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      ce_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          err_q <= 1'b0;
          if (m_bus.m_ce_i) begin
            we_q    <= m_bus.m_we_i;
            addr_q  <= m_bus.m_addr_i;
            sel_q   <= m_bus.m_sel_i;
            wdata_q <= m_bus.m_data_i;
            if (mapped_s) begin
              ce_q    <= onehot_s;
              state_q <= ST_BUSY;
            end else begin
              rdata_q  <= {DATA_W{ERR_DATA_BIT}};
              err_q    <= 1'b1;
              sticky_q <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          // Ack is checked first so a last-cycle ack beats the timeout
          if (ack_s) begin
            if (!we_q) begin
              rdata_q <= rdata_sel_s;
            end
            ce_q    <= '0;
            state_q <= ST_DONE;
          end else if (reached_s) begin
            rdata_q  <= {DATA_W{ERR_DATA_BIT}};
            err_q    <= 1'b1;
            sticky_q <= 1'b1;
            ce_q     <= '0;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ce_q    <= '0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_bus.m_data_o  = rdata_q;
  assign m_bus.m_stall_o = stall_s;
  assign m_bus.m_err_o   = err_q;
  assign err_sticky_o    = sticky_q;
  assign s_ce_o          = ce_q;
  assign s_we_o          = we_q;
  assign s_addr_o        = addr_q;
  assign s_sel_o         = sel_q;
  assign s_data_o        = wdata_q;
endmodule

// File: tb/tb_sopc_data_bus.sv
// Directed self-checking bench: a 4-slave fabric for the main traffic and a
// 3-slave fabric for the unmapped-address case.
module tb_sopc_data_bus;
  logic clk;
  logic rst;

  sopc_data_bus_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();
  sopc_data_bus_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  logic         sticky4, sticky3;
  logic [3:0]   s_ce4;
  logic [2:0]   s_ce3;
  logic         s_we4, s_we3;
  logic [31:0]  s_addr4, s_addr3;
  logic [3:0]   s_sel4, s_sel3;
  logic [31:0]  s_wd4, s_wd3;
  logic [127:0] s_data4;
  logic [95:0]  s_data3;
  logic [3:0]   s_ack4;
  logic [2:0]   s_ack3;

  int checks = 0;
  int errors = 0;

  sopc_data_bus #(.NUM_SLAVES(4), .SEL_BITS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut4 (
    .clk(clk), .rst(rst), .m_bus(bus4), .err_sticky_o(sticky4),
    .s_ce_o(s_ce4), .s_we_o(s_we4), .s_addr_o(s_addr4), .s_sel_o(s_sel4),
    .s_data_o(s_wd4), .s_data_i(s_data4), .s_ack_i(s_ack4)
  );

  sopc_data_bus #(.NUM_SLAVES(3), .SEL_BITS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut3 (
    .clk(clk), .rst(rst), .m_bus(bus3), .err_sticky_o(sticky3),
    .s_ce_o(s_ce3), .s_we_o(s_we3), .s_addr_o(s_addr3), .s_sel_o(s_sel3),
    .s_data_o(s_wd3), .s_data_i(s_data3), .s_ack_i(s_ack3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on the 4-slave fabric. ack_cyc = BUSY cycle (1-based) in which
  // the addressed slave acks, 0 = never. noise = acks on other slaves each cycle.
  task automatic access4(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd, input int ack_cyc, input logic [31:0] ack_data,
                         input logic [3:0] noise, output int stalls, output logic [3:0] ce_seen,
                         output logic we_seen, output logic [3:0] sel_seen,
                         output logic [31:0] wd_seen);
    int idx;
    int n;
    idx = int'(addr[31:30]);
    stalls = 0; ce_seen = '0; we_seen = 1'b0; sel_seen = '0; wd_seen = '0;
    bus4.m_ce_i = 1'b1; bus4.m_we_i = we; bus4.m_addr_i = addr;
    bus4.m_sel_i = sel; bus4.m_data_i = wd;
    @(negedge clk);
    if (bus4.m_stall_o) stalls++;
    step();
    // Scramble core inputs; they must not be re-sampled while BUSY
    bus4.m_ce_i = 1'b0; bus4.m_we_i = ~we; bus4.m_addr_i = ~addr;
    bus4.m_sel_i = ~sel; bus4.m_data_i = ~wd;
    n = 1;
    while (n < 40) begin
      s_ack4  = noise;
      if (n == ack_cyc) s_ack4[idx] = 1'b1;
      s_data4 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0F0F_0F0F};
      s_data4[idx*32 +: 32] = ack_data;
      @(negedge clk);
      if (n == 1) begin
        ce_seen = s_ce4; we_seen = s_we4; sel_seen = s_sel4; wd_seen = s_wd4;
      end
      if (!bus4.m_stall_o) break;
      stalls++;
      step();
      n++;
    end
    check_eq("access_bound", 32'(n < 40), 32'd1);
    s_ack4 = '0;
  endtask

  int          stalls;
  logic [3:0]  ce_seen;
  logic        we_seen;
  logic [3:0]  sel_seen;
  logic [31:0] wd_seen;

  initial begin
    rst = 1'b1;
    bus4.m_ce_i = 1'b0; bus4.m_we_i = 1'b0; bus4.m_addr_i = '0; bus4.m_sel_i = '0; bus4.m_data_i = '0;
    bus3.m_ce_i = 1'b0; bus3.m_we_i = 1'b0; bus3.m_addr_i = '0; bus3.m_sel_i = '0; bus3.m_data_i = '0;
    s_ack4 = '0; s_data4 = '0;
    s_ack3 = '0; s_data3 = {32'h2222_2222, 32'h1111_1111, 32'h7777_7777};

    // Reset state
    @(negedge clk);
    check_eq("rst_data", bus4.m_data_o, 32'h0);
    check_eq("rst_err", 32'(bus4.m_err_o), 32'd0);
    check_eq("rst_sticky", 32'(sticky4), 32'd0);
    check_eq("rst_ce", 32'(s_ce4), 32'h0);
    check_eq("rst_stall", 32'(bus4.m_stall_o), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Read slave 1, ack in third BUSY cycle
    access4(1'b0, 32'h4000_0010, 4'hF, 32'h0BAD_0BAD, 3, 32'hDEAD_BEEF, 4'b0000,
            stalls, ce_seen, we_seen, sel_seen, wd_seen);
    check_eq("rd1_ce", 32'(ce_seen), 32'h2);
    check_eq("rd1_stalls", 32'(stalls), 32'd4);
    check_eq("rd1_data", bus4.m_data_o, 32'hDEAD_BEEF);
    check_eq("rd1_err", 32'(bus4.m_err_o), 32'd0);
    check_eq("rd1_done_ce", 32'(s_ce4), 32'h0);
    step();

    // Write slave 0, ack in first BUSY cycle
    access4(1'b1, 32'h0000_0004, 4'b0011, 32'h1234_5678, 1, 32'h9999_9999, 4'b0000,
            stalls, ce_seen, we_seen, sel_seen, wd_seen);
    check_eq("wr_ce", 32'(ce_seen), 32'h1);
    check_eq("wr_we", 32'(we_seen), 32'd1);
    check_eq("wr_sel", 32'(sel_seen), 32'h3);
    check_eq("wr_data", wd_seen, 32'h1234_5678);
    check_eq("wr_stalls", 32'(stalls), 32'd2);
    check_eq("wr_rdata_kept", bus4.m_data_o, 32'hDEAD_BEEF);
    check_eq("wr_err", 32'(bus4.m_err_o), 32'd0);
    // DONE bubble: a request here is ignored and no stall is raised
    bus4.m_ce_i = 1'b1; bus4.m_addr_i = 32'h4000_0000; bus4.m_we_i = 1'b0;
    #1;
    check_eq("done_ignore_stall", 32'(bus4.m_stall_o), 32'd0);
    step();
    bus4.m_ce_i = 1'b0;
    @(negedge clk);
    check_eq("done_ignore_ce", 32'(s_ce4), 32'h0);
    step();

    // Slave 2 never acks; slave 3 acks throughout (ignored) -> timeout
    access4(1'b0, 32'h8000_0000, 4'hF, 32'h0BAD_0BAD, 0, 32'h5555_5555, 4'b1000,
            stalls, ce_seen, we_seen, sel_seen, wd_seen);
    check_eq("to_ce", 32'(ce_seen), 32'h4);
    check_eq("to_stalls", 32'(stalls), 32'd16);
    check_eq("to_data", bus4.m_data_o, 32'h0);
    check_eq("to_err", 32'(bus4.m_err_o), 32'd1);
    check_eq("to_sticky", 32'(sticky4), 32'd1);
    step();
    @(negedge clk);
    check_eq("to_err_pulse", 32'(bus4.m_err_o), 32'd0);
    step();

    // Ack in the 15th BUSY cycle: ack beats timeout
    access4(1'b0, 32'h8000_0008, 4'hF, 32'h0BAD_0BAD, 15, 32'hCAFE_F00D, 4'b0000,
            stalls, ce_seen, we_seen, sel_seen, wd_seen);
    check_eq("ack15_stalls", 32'(stalls), 32'd16);
    check_eq("ack15_data", bus4.m_data_o, 32'hCAFE_F00D);
    check_eq("ack15_err", 32'(bus4.m_err_o), 32'd0);
    check_eq("ack15_sticky", 32'(sticky4), 32'd1);
    step();

    // 3-slave fabric: a good read to slave 0, then an unmapped access
    bus3.m_ce_i = 1'b1; bus3.m_addr_i = 32'h0000_0000; s_ack3 = 3'b001;
    step();
    bus3.m_ce_i = 1'b0;
    step();
    @(negedge clk);
    check_eq("u_pre_data", bus3.m_data_o, 32'h7777_7777);
    s_ack3 = '0;
    step();
    bus3.m_ce_i = 1'b1; bus3.m_addr_i = 32'hC000_0000;
    @(negedge clk);
    check_eq("u_stall", 32'(bus3.m_stall_o), 32'd1);
    step();
    bus3.m_ce_i = 1'b0;
    @(negedge clk);
    check_eq("u_done_stall", 32'(bus3.m_stall_o), 32'd0);
    check_eq("u_ce", 32'(s_ce3), 32'h0);
    check_eq("u_data", bus3.m_data_o, 32'h0);
    check_eq("u_err", 32'(bus3.m_err_o), 32'd1);
    check_eq("u_sticky", 32'(sticky3), 32'd1);
    step();
    @(negedge clk);
    check_eq("u_err_pulse", 32'(bus3.m_err_o), 32'd0);
    step();
    step();
    @(negedge clk);
    check_eq("u_sticky_held", 32'(sticky3), 32'd1);
    step();

    // Reset in the middle of a BUSY access on slave 1
    bus4.m_ce_i = 1'b1; bus4.m_we_i = 1'b1; bus4.m_addr_i = 32'h4000_0000;
    bus4.m_sel_i = 4'hF; bus4.m_data_i = 32'h0BAD_0BAD;
    step();
    bus4.m_ce_i = 1'b0;
    @(negedge clk);
    check_eq("mid_ce", 32'(s_ce4), 32'h2);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check_eq("mid_rst_ce", 32'(s_ce4), 32'h0);
    check_eq("mid_rst_we", 32'(s_we4), 32'd0);
    check_eq("mid_rst_addr", s_addr4, 32'h0);
    check_eq("mid_rst_sel", 32'(s_sel4), 32'h0);
    check_eq("mid_rst_wd", s_wd4, 32'h0);
    check_eq("mid_rst_data", bus4.m_data_o, 32'h0);
    check_eq("mid_rst_sticky", 32'(sticky4), 32'd0);
    check_eq("mid_rst_sticky3", 32'(sticky3), 32'd0);
    check_eq("mid_rst_stall", 32'(bus4.m_stall_o), 32'd0);
    rst = 1'b0;
    step();
    @(negedge clk);
    check_eq("post_rst_ce", 32'(s_ce4), 32'h0);
    step();

    // Normal read to slave 0 after reset, ack in second BUSY cycle
    access4(1'b0, 32'h0000_0020, 4'hF, 32'h0BAD_0BAD, 2, 32'hA5A5_0001, 4'b0100,
            stalls, ce_seen, we_seen, sel_seen, wd_seen);
    check_eq("post_ce", 32'(ce_seen), 32'h1);
    check_eq("post_stalls", 32'(stalls), 32'd3);
    check_eq("post_data", bus4.m_data_o, 32'hA5A5_0001);
    check_eq("post_err", 32'(bus4.m_err_o), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sopc_data_bus.md
# sopc_data_bus

Parametrised data-side bus fabric between the OpenMIPS core's data-memory port and up to NUM_SLAVES memory-mapped slaves (data RAM, peripherals). It decodes the upper address bits to select a slave, holds the request until the slave acknowledges, stalls the core meanwhile, and returns registered read data. It replaces the direct single-RAM hookup with multi-slave decode, variable-latency slaves, timeout and bus-error reporting.

## Interface
- NUM_SLAVES, 4, number of slave ports (1..2^SEL_BITS)
- SEL_BITS, 2, address MSBs used as slave index
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- TIMEOUT, 15, BUSY cycles without ack before error termination (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- m_ce_i  in  1  core request valid
- m_we_i  in  1  1 = write, 0 = read
- m_addr_i  in  ADDR_W  byte address
- m_sel_i  in  DATA_W/8  byte enables
- m_data_i  in  DATA_W  write data
- m_data_o  out  DATA_W  read data, registered
- m_stall_o  out  1  stall request to core pipeline
- m_err_o  out  1  one-cycle pulse: timeout or unmapped access
- err_sticky_o  out  1  set by any error, cleared only by reset
- s_ce_o  out  NUM_SLAVES  one-hot slave select
- s_we_o  out  1  latched write strobe
- s_addr_o  out  ADDR_W  latched address
- s_sel_o  out  DATA_W/8  latched byte enables
- s_data_o  out  DATA_W  latched write data
- s_data_i  in  NUM_SLAVES*DATA_W  slave read data, slave k at bits [k*DATA_W +: DATA_W]
- s_ack_i  in  NUM_SLAVES  slave done; only the selected slave's bit is honoured

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: m_stall_o = m_ce_i (combinational). On m_ce_i=1 latch we/addr/sel/data, idx = m_addr_i[ADDR_W-1 -: SEL_BITS].
  - idx < NUM_SLAVES → BUSY, cycle counter cleared.
  - idx ≥ NUM_SLAVES (unmapped) → DONE with m_data_o=0, m_err_o pulse, sticky set; no s_ce_o asserted.
- BUSY: s_ce_o = one-hot(idx), slave bus driven from latches; m_stall_o=1.
  - s_ack_i[idx]=1 → capture s_data_i slice into m_data_o (reads only; writes leave m_data_o unchanged) → DONE.
  - counter reaches TIMEOUT with no ack → m_data_o=0, m_err_o pulse, sticky set → DONE.
  - Ack and timeout same cycle: ack wins, no error.
  - Acks on non-selected bits ignored.
- DONE: s_ce_o=0, m_stall_o=0; core consumes m_data_o. m_ce_i ignored this cycle; → IDLE unconditionally.
- Core inputs are not re-sampled in BUSY; changes there have no effect.
- Reset (any time, incl. mid-BUSY): state IDLE, all latches 0, s_ce_o=0, m_data_o=0, m_err_o=0, err_sticky_o=0, counter 0. An in-flight slave access is abandoned.

## Timing
- Request seen at IDLE edge T; BUSY from T+1; slave ack at cycle T+k (k≥1) → DONE at T+k+1; stall high for cycles T..T+k, low at T+k+1.
- Minimum read latency: 2 stall cycles (ack in first BUSY cycle).
- Timeout: BUSY lasts exactly TIMEOUT cycles; error pulse coincides with first DONE cycle.
- Unmapped: 1 stall cycle, error pulse in following DONE cycle.
- Back-to-back: next request accepted earliest two cycles after previous acceptance plus slave latency (DONE is a bubble).
- m_err_o high exactly one cycle per errored access.

## Structure
- Package sopc_bus_pkg: state encoding (IDLE/BUSY/DONE), default TIMEOUT, error-data constant (0), byte-enable width function DATA_W/8.
- One sub-module: sopc_bus_watchdog (counter with clear, enable, TIMEOUT-reached output); everything else in sopc_data_bus.

## Test plan
- Read slave 1, addr 0x4000_0010, ack after 3 BUSY cycles with data 0xDEAD_BEEF → s_ce_o=4'b0010, stall 4 cycles, m_data_o=0xDEAD_BEEF in DONE, no error.
- Write slave 0, addr 0x0000_0004, sel 4'b0011, data 0x1234_5678, ack first cycle → s_we_o=1, s_sel_o=4'b0011, s_data_o=0x1234_5678, stall 2 cycles, m_data_o unchanged.
- NUM_SLAVES=3, access 0xC000_0000 → no s_ce_o, m_data_o=0, m_err_o one pulse, err_sticky_o=1 until reset.
- Slave 2 never acks, TIMEOUT=15 → BUSY exactly 15 cycles, m_data_o=0, m_err_o pulse; ack on slave 3 during BUSY ignored.
- Ack on cycle 15 exactly (same as timeout) → data returned, m_err_o=0.
- Assert rst mid-BUSY → next cycle all outputs 0, state IDLE; subsequent read to slave 0 completes normally.
